// File: rtl/multiplier_seq_8bit_if.sv
// ---------------------------------------------------------------------------
// multiplier_seq_8bit_if
//   Handshake/operand bundle for the sequential multiply-accumulate unit.
//   master : requester (drives start/Q/B/R, observes results)
//   slave  : multiplier core (observes request, drives results/status)
//
//   start  request, sampled only while the core is idle
//   Q      multiplier (quotient)
//   B      multiplicand (divisor)
//   R      addend (remainder), zero-extended
//   P      result Q*B+R, held until the next completion
//   ovf    result does not fit in WIDTH bits
//   inv    operands are not a legal divide triple (B==0 or R>=B)
//   busy   high while the core is iterating
//   done   one-cycle completion pulse
// ---------------------------------------------------------------------------
interface multiplier_seq_8bit_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       Q;
    logic [WIDTH-1:0]       B;
    logic [WIDTH-1:0]       R;
    logic [2*WIDTH-1:0]     P;
    logic                   ovf;
    logic                   inv;
    logic                   busy;
    logic                   done;

    modport master (
        output start, Q, B, R,
        input  P, ovf, inv, busy, done
    );

    modport slave (
        input  start, Q, B, R,
        output P, ovf, inv, busy, done
    );
endinterface

// File: rtl/multiplier_seq_8bit.sv
// ---------------------------------------------------------------------------
// multiplier_seq_8bit
//   Shift-add multiply-accumulate: P = Q*B + R. Rebuilds a dividend from a
//   quotient/divisor/remainder triple, so it doubles as the ALU multiply
//   (R=0) and as a consistency checker for divide results.
//
//   Ports
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    multiplier_seq_8bit_if.slave (start/Q/B/R in, P/ovf/inv/busy/done out)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; operands latched on the accepting edge
//   CALC   | WIDTH shift-add iterations, busy=1
//   DONE   | one-cycle done pulse; start is ignored here
// ---------------------------------------------------------------------------
module multiplier_seq_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multiplier_seq_8bit_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_inv_l;

    logic [PW-1:0]      r_p;
    logic               r_ovf;
    logic               r_inv;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [PW-1:0]      w_acc_next;
    logic               w_inv_in;

    // Iteration counter runs down from WIDTH-1; the terminal count marks the
    // final shift-add so the result is captured on that same edge.
    assign w_last = (r_cnt == '0);

    // Accumulator cannot wrap: (2^W-1)^2 + (2^W-1) < 2^(2W).
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_inv_in = (bus.B == '0) || (bus.R >= bus.B);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand latch and shift-add iteration
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_inv_l  <= 1'b0;
        end else if (w_load) begin
            r_acc    <= {{WIDTH{1'b0}}, bus.R};
            r_mcand  <= {{WIDTH{1'b0}}, bus.B};
            r_mplier <= bus.Q;
            r_cnt    <= CW'(WIDTH - 1);
            r_inv_l  <= w_inv_in;
        end else if (w_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: updated only when the last iteration completes, so
    // they hold the previous result throughout a new calculation.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
            r_inv <= 1'b0;
        end else if (w_step && w_last) begin
            r_p   <= w_acc_next;
            r_ovf <= |w_acc_next[PW-1:WIDTH];
            r_inv <= r_inv_l;
        end
    end

    assign bus.P    = r_p;
    assign bus.ovf  = r_ovf;
    assign bus.inv  = r_inv;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule
